sample_pair_feeder: RTL and testbench

Upstream feeder for the first-order filter `sequence` stage: accepts a stream of samples over a valid/ready handshake and buffers them in a small FIFO. It maintains a two-tap history and presents the current/previous pair (`x_n`, `x_n_1`) together with a one-cycle `enable_start` strobe per new pair. It decouples the sample source from the filter core's pacing (`out_ready`) and handles the priming of the history after reset or flush.

---
 rtl/sample_pair_feeder_if.sv | 36 +++
 rtl/sample_pair_feeder.sv | 123 ++++++++++++
 tb/tb_sample_pair_feeder.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/sample_pair_feeder_if.sv
// Handshake bundle between the sample source, the pair feeder and the filter core.
// The master drives samples and out_ready; the slave (feeder) returns in_ready and the pair.
interface sample_pair_feeder_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             out_ready;
  logic [WIDTH-1:0] x_n;
  logic [WIDTH-1:0] x_n_1;
  logic             enable_start;
  logic [15:0]      pair_count;

  modport master (
    output in_data,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  x_n,
    input  x_n_1,
    input  enable_start,
    input  pair_count
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output x_n,
    output x_n_1,
    output enable_start,
    output pair_count
  );
endinterface

// File: rtl/sample_pair_feeder.sv
// Buffers samples in a small FIFO and issues (x_n, x_n_1) pairs with a one-cycle strobe.
// Define SAMPLE_PAIR_ZERO_PRIME_EN to issue the first pair on the first pop with x_n_1 = 0.
module sample_pair_feeder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input logic                 clk,
  input logic                 reset,
  input logic                 flush,
  sample_pair_feeder_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef enum logic [1:0] {StEmpty, StPrime, StRun} state_e;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW:0]    r_wr_ptr;
  logic [PtrW:0]    r_rd_ptr;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_rd_data;

  state_e           r_state;
  state_e           w_state_d;
  logic [WIDTH-1:0] r_x_n;
  logic [WIDTH-1:0] w_x_n_d;
  logic [WIDTH-1:0] r_x_n_1;
  logic [WIDTH-1:0] w_x_n_1_d;
  logic             r_strobe;
  logic             w_strobe_d;
  logic [15:0]      r_count;
  logic [15:0]      w_count_d;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[PtrW] != r_rd_ptr[PtrW]) &&
                     (r_wr_ptr[PtrW-1:0] == r_rd_ptr[PtrW-1:0]);
  assign w_push    = bus.in_valid && !w_full && !flush;
  assign w_pop     = !w_empty && bus.out_ready && !flush;
  assign w_rd_data = r_mem[r_rd_ptr[PtrW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[PtrW-1:0]] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_x_n_d    = r_x_n;
    w_x_n_1_d  = r_x_n_1;
    w_strobe_d = 1'b0;
    w_count_d  = r_count;
    if (flush) begin
      w_state_d = StEmpty;
      w_x_n_d   = '0;
      w_x_n_1_d = '0;
    end else if (w_pop) begin
      w_x_n_d = w_rd_data;
      case (r_state)
        StEmpty: begin
          w_x_n_1_d = '0;
`ifdef SAMPLE_PAIR_ZERO_PRIME_EN
          w_strobe_d = 1'b1;
          w_count_d  = r_count + 16'd1;
          w_state_d  = StRun;
`else
          w_state_d = StPrime;
`endif
        end
        default: begin
          w_x_n_1_d  = r_x_n;
          w_strobe_d = 1'b1;
          w_count_d  = r_count + 16'd1;
          w_state_d  = StRun;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StEmpty;
      r_x_n    <= '0;
      r_x_n_1  <= '0;
      r_strobe <= 1'b0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_d;
      r_x_n    <= w_x_n_d;
      r_x_n_1  <= w_x_n_1_d;
      r_strobe <= w_strobe_d;
      r_count  <= w_count_d;
    end
  end

  assign bus.in_ready     = !w_full;
  assign bus.x_n          = r_x_n;
  assign bus.x_n_1        = r_x_n_1;
  assign bus.enable_start = r_strobe;
  assign bus.pair_count   = r_count;

endmodule

// File: tb/tb_sample_pair_feeder.sv
// Randomised and directed checks of sample_pair_feeder against a queue-based reference model.
module tb_sample_pair_feeder;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;
`ifdef SAMPLE_PAIR_ZERO_PRIME_EN
  localparam int PrimePops = 0;
`else
  localparam int PrimePops = 1;
`endif

  logic clk;
  logic reset;
  logic flush;

  sample_pair_feeder_if #(.WIDTH(WIDTH)) bus ();

  sample_pair_feeder #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .flush(flush),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference model: FIFO as a queue, history as two values, priming as a pop count.
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_xn;
  logic [WIDTH-1:0] m_xn1;
  logic             m_str;
  logic [15:0]      m_cnt;
  int               m_pops;

  logic [63:0]      dlog[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear(input bit full_reset);
    m_q.delete();
    m_xn   = '0;
    m_xn1  = '0;
    m_str  = 1'b0;
    m_pops = 0;
    if (full_reset) m_cnt = '0;
  endtask

  task automatic check_outputs();
    chk("x_n", 64'(bus.x_n), 64'(m_xn));
    chk("x_n_1", 64'(bus.x_n_1), 64'(m_xn1));
    chk("enable_start", 64'(bus.enable_start), 64'(m_str));
    chk("pair_count", 64'(bus.pair_count), 64'(m_cnt));
    if (bus.enable_start === 1'b1) dlog.push_back({bus.x_n, bus.x_n_1});
  endtask

  // One clock cycle; entered and left at a falling edge.
  task automatic step(input bit v, input logic [WIDTH-1:0] d, input bit ordy, input bit fl);
    bit do_push;
    bit do_pop;
    logic [WIDTH-1:0] s;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    flush         = fl;
    #1;
    chk("in_ready", 64'(bus.in_ready), 64'(m_q.size() < DEPTH));
    do_push = v && (m_q.size() < DEPTH) && !fl;
    do_pop  = (m_q.size() > 0) && ordy && !fl;
    @(posedge clk);
    if (fl) begin
      model_clear(1'b0);
    end else begin
      m_str = 1'b0;
      if (do_pop) begin
        s     = m_q.pop_front();
        m_xn1 = m_xn;
        m_xn  = s;
        if (m_pops >= PrimePops) begin
          m_str = 1'b1;
          m_cnt = m_cnt + 16'd1;
        end
        m_pops++;
      end
      if (do_push) m_q.push_back(d);
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic chk_log(input string name, input logic [63:0] exp[$]);
    chk({name, "_len"}, 64'(dlog.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < dlog.size(); i++) begin
      chk(name, dlog[i], exp[i]);
    end
    dlog.delete();
  endtask

  initial begin
    logic [63:0] exp[$];
    int guard;
    n_vec         = 0;
    n_err         = 0;
    reset         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    model_clear(1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_x_n", 64'(bus.x_n), 64'd0);
    chk("rst_x_n_1", 64'(bus.x_n_1), 64'd0);
    chk("rst_strobe", 64'(bus.enable_start), 64'd0);
    chk("rst_count", 64'(bus.pair_count), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Priming: 1,2,3,4 streamed straight through.
    for (int i = 1; i <= 4; i++) step(1'b1, WIDTH'(i), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
`ifdef SAMPLE_PAIR_ZERO_PRIME_EN
    exp = '{{32'd1, 32'd0}, {32'd2, 32'd1}, {32'd3, 32'd2}, {32'd4, 32'd3}};
    chk("prime_count", 64'(bus.pair_count), 64'd4);
`else
    exp = '{{32'd2, 32'd1}, {32'd3, 32'd2}, {32'd4, 32'd3}};
    chk("prime_count", 64'(bus.pair_count), 64'd3);
`endif
    chk_log("prime_pair", exp);

    // Backpressure: only 10..13 fit while out_ready is low.
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 10; i <= 15; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    repeat (5) step(1'b0, '0, 1'b1, 1'b0);
`ifdef SAMPLE_PAIR_ZERO_PRIME_EN
    exp = '{{32'd10, 32'd0}, {32'd11, 32'd10}, {32'd12, 32'd11}, {32'd13, 32'd12}};
`else
    exp = '{{32'd11, 32'd10}, {32'd12, 32'd11}, {32'd13, 32'd12}};
`endif
    chk_log("drain_pair", exp);
    chk("drain_in_ready", 64'(bus.in_ready), 64'd1);

    // Flush beats a simultaneous push and pending pop.
    step(1'b1, 32'd21, 1'b0, 1'b0);
    step(1'b1, 32'd22, 1'b0, 1'b0);
    step(1'b1, 32'd23, 1'b1, 1'b1);
    chk("flush_x_n", 64'(bus.x_n), 64'd0);
    chk("flush_x_n_1", 64'(bus.x_n_1), 64'd0);
    chk("flush_strobe", 64'(bus.enable_start), 64'd0);
    step(1'b1, 32'd31, 1'b0, 1'b0);
    step(1'b1, 32'd32, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
`ifdef SAMPLE_PAIR_ZERO_PRIME_EN
    exp = '{{32'd31, 32'd0}, {32'd32, 32'd31}};
`else
    exp = '{{32'd32, 32'd31}};
`endif
    chk_log("reprime_pair", exp);

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(3) != 0), $urandom, ($urandom_range(2) != 0),
           ($urandom_range(40) == 0));
    end
    dlog.delete();

    // Asynchronous reset mid-stream with samples buffered.
    step(1'b1, 32'h55, 1'b1, 1'b0);
    step(1'b1, 32'h66, 1'b1, 1'b0);
    step(1'b1, 32'h77, 1'b0, 1'b0);
    step(1'b1, 32'h88, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_x_n", 64'(bus.x_n), 64'd0);
    chk("arst_x_n_1", 64'(bus.x_n_1), 64'd0);
    chk("arst_strobe", 64'(bus.enable_start), 64'd0);
    chk("arst_count", 64'(bus.pair_count), 64'd0);
    chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
    model_clear(1'b1);
    @(negedge clk);
    reset = 1'b0;
    check_outputs();
    dlog.delete();

    // Run the pair counter up to 0xFFFF, then one more pair wraps it.
    guard = 0;
    while (m_cnt != 16'hFFFF && guard < 70000) begin
      step(1'b1, $urandom, 1'b1, 1'b0);
      dlog.delete();
      guard++;
    end
    chk("wrap_reached", 64'(guard < 70000), 64'd1);
    chk("pre_wrap_count", 64'(bus.pair_count), 64'hFFFF);
    step(1'b1, $urandom, 1'b1, 1'b0);
    chk("wrap_count", 64'(bus.pair_count), 64'd0);
    chk("wrap_strobe", 64'(bus.enable_start), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
